// File: rtl/rv32_pkg.sv
// =============================================================================
// rv32_pkg : shared writeback encodings and FSM state type
// Rev 1.0
// =============================================================================
`default_nettype none

package rv32_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_IMM  = 2'b11;

  localparam logic [1:0] LOAD_BYTE = 2'b00;
  localparam logic [1:0] LOAD_HALF = 2'b01;
  localparam logic [1:0] LOAD_WORD = 2'b10;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/load_align_ext.sv
// =============================================================================
// load_align_ext : selects the addressed byte/half of a load word and extends it
// Rev 1.0
// =============================================================================
`default_nettype none

module load_align_ext (
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);
  import rv32_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (offset)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    // Misaligned halfwords never reach this point, so only offset[1] matters.
    w_half = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (size)
      LOAD_BYTE: data = {{24{~is_unsigned & w_byte[7]}}, w_byte};
      LOAD_HALF: data = {{16{~is_unsigned & w_half[15]}}, w_half};
      default:   data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv32_writeback_unit.sv
// =============================================================================
// rv32_writeback_unit : retires MEM-stage instructions into the register file
// Rev 1.0
// =============================================================================
`default_nettype none

module rv32_writeback_unit #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int XLEN         = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            wb_valid_in,
  output logic            wb_ready_out,
  input  logic [4:0]      rd_addr_in,
  input  logic            rd_we_in,
  input  logic [1:0]      wb_sel_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [1:0]      load_size_in,
  input  logic            load_unsigned_in,
  input  logic            dmem_rvalid_in,
  input  logic [XLEN-1:0] dmem_rdata_in,
  input  logic            flush_in,
  output logic            wr_en_out,
  output logic [4:0]      rd_addr_out,
  output logic [XLEN-1:0] rd_data_out,
  output logic            busy_out,
  output logic            err_out
);
  import rv32_pkg::*;

  localparam logic [7:0] C_CNT_LAST = 8'(LOAD_TIMEOUT - 1);

  wb_state_t       r_state, w_state_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic [4:0]      r_ld_rd;
  logic            r_ld_we;
  logic [1:0]      r_ld_size;
  logic            r_ld_uns;
  logic [1:0]      r_ld_off;

  logic            w_accept;
  logic            w_capture;
  logic [XLEN-1:0] w_result;
  logic [XLEN-1:0] w_load_data;
  logic            w_wr_en_nxt;
  logic [4:0]      w_rd_addr_nxt;
  logic [XLEN-1:0] w_rd_data_nxt;
  logic            w_err_nxt;

  assign wb_ready_out = (r_state == IDLE) && !rst_in;
  assign busy_out     = (r_state == WAIT_LOAD);
  assign w_accept     = wb_valid_in && wb_ready_out && !flush_in;

  always_comb begin
    case (wb_sel_in)
      WB_SEL_PC4: w_result = pc_in + XLEN'(4);
      WB_SEL_IMM: w_result = imm_in;
      default:    w_result = alu_result_in;
    endcase
  end

  load_align_ext u_align (
    .rdata       (dmem_rdata_in),
    .offset      (r_ld_off),
    .size        (r_ld_size),
    .is_unsigned (r_ld_uns),
    .data        (w_load_data)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_capture     = 1'b0;
    w_wr_en_nxt   = 1'b0;
    w_rd_addr_nxt = rd_addr_out;
    w_rd_data_nxt = rd_data_out;
    w_err_nxt     = err_out;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (wb_sel_in == WB_SEL_LOAD) begin
            w_state_nxt = WAIT_LOAD;
            w_cnt_nxt   = 8'd0;
            w_capture   = 1'b1;
          end else begin
            w_wr_en_nxt   = rd_we_in && (rd_addr_in != 5'd0);
            w_rd_addr_nxt = rd_addr_in;
            w_rd_data_nxt = w_result;
          end
        end
      end
      WAIT_LOAD: begin
        // Flush wins over a same-cycle response; response wins over timeout.
        if (flush_in) begin
          w_state_nxt = IDLE;
        end else if (dmem_rvalid_in) begin
          w_state_nxt   = IDLE;
          w_wr_en_nxt   = r_ld_we && (r_ld_rd != 5'd0);
          w_rd_addr_nxt = r_ld_rd;
          w_rd_data_nxt = w_load_data;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      wr_en_out   <= 1'b0;
      rd_addr_out <= 5'd0;
      rd_data_out <= '0;
      err_out     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      wr_en_out   <= w_wr_en_nxt;
      rd_addr_out <= w_rd_addr_nxt;
      rd_data_out <= w_rd_data_nxt;
      err_out     <= w_err_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ld_rd   <= 5'd0;
      r_ld_we   <= 1'b0;
      r_ld_size <= LOAD_WORD;
      r_ld_uns  <= 1'b0;
      r_ld_off  <= 2'd0;
    end else if (w_capture) begin
      r_ld_rd   <= rd_addr_in;
      r_ld_we   <= rd_we_in;
      r_ld_size <= load_size_in;
      r_ld_uns  <= load_unsigned_in;
      r_ld_off  <= alu_result_in[1:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv32_writeback_unit.sv
// =============================================================================
// tb_rv32_writeback_unit : directed stimulus against a transaction-level model
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_rv32_writeback_unit;
  import rv32_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  rd_addr = '0;
  logic        rd_we = 1'b0;
  logic [1:0]  wb_sel = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] pc = '0;
  logic [31:0] imm = '0;
  logic [1:0]  load_size = '0;
  logic        load_unsigned = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        flush = 1'b0;
  logic        wr_en;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  rv32_writeback_unit #(.LOAD_TIMEOUT(TO), .XLEN(32)) dut (
    .clk_in(clk), .rst_in(rst), .wb_valid_in(wb_valid), .wb_ready_out(wb_ready),
    .rd_addr_in(rd_addr), .rd_we_in(rd_we), .wb_sel_in(wb_sel),
    .alu_result_in(alu_result), .pc_in(pc), .imm_in(imm),
    .load_size_in(load_size), .load_unsigned_in(load_unsigned),
    .dmem_rvalid_in(dmem_rvalid), .dmem_rdata_in(dmem_rdata), .flush_in(flush),
    .wr_en_out(wr_en), .rd_addr_out(rd_addr_o), .rd_data_out(rd_data_o),
    .busy_out(busy), .err_out(err)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Expected DUT-visible state for the current cycle
  logic        exp_wr = 1'b0, exp_busy = 1'b0, exp_err = 1'b0, exp_ready = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;

  // Outstanding load as the model sees it
  logic [4:0]  p_rd = '0;
  logic        p_we = 1'b0;
  logic [1:0]  p_size = '0;
  logic        p_uns = 1'b0;
  logic [31:0] p_addr = '0;
  int          wait_n = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] m_result(input logic [1:0] sel, input logic [31:0] a,
                                           input logic [31:0] p, input logic [31:0] i);
    if (sel == WB_SEL_PC4) return p + 32'd4;
    if (sel == WB_SEL_IMM) return i;
    return a;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] addr,
                                         input logic [1:0] size, input logic uns);
    logic [31:0] v;
    if (size == LOAD_BYTE) begin
      v = (rdata >> (8 * addr[1:0])) & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (size == LOAD_HALF) begin
      v = (rdata >> (16 * addr[1])) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_en",   32'(wr_en),    32'(exp_wr));
      check("rd_addr", 32'(rd_addr_o), 32'(exp_addr));
      check("rd_data", rd_data_o,     exp_data);
      check("busy",    32'(busy),     32'(exp_busy));
      check("err",     32'(err),      32'(exp_err));
      check("ready",   32'(wb_ready), 32'(exp_ready));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    exp_wr = 1'b0;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                       input logic [31:0] a, input logic [31:0] p, input logic [31:0] i,
                       input logic [1:0] sz, input logic uns);
    wb_valid = 1'b1; wb_sel = sel; rd_addr = rd; rd_we = we;
    alu_result = a; pc = p; imm = i; load_size = sz; load_unsigned = uns;
    flush = 1'b0; dmem_rvalid = 1'b0;
    cycle();
    wb_valid = 1'b0;
    if (sel == WB_SEL_LOAD) begin
      p_rd = rd; p_we = we; p_size = sz; p_uns = uns; p_addr = a; wait_n = 0;
      exp_busy = 1'b1; exp_ready = 1'b0;
    end else begin
      exp_wr = we && (rd != 5'd0); exp_addr = rd; exp_data = m_result(sel, a, p, i);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      wb_valid = 1'b0; flush = 1'b0; dmem_rvalid = 1'b0;
      cycle();
    end
  endtask

  task automatic wait_cycle();
    dmem_rvalid = 1'b0;
    cycle();
    wait_n++;
    if (wait_n == TO) begin
      exp_err = 1'b1; exp_busy = 1'b0; exp_ready = 1'b1;
    end
  endtask

  task automatic respond(input logic [31:0] rdata);
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    cycle();
    dmem_rvalid = 1'b0;
    exp_busy = 1'b0; exp_ready = 1'b1;
    exp_wr = p_we && (p_rd != 5'd0); exp_addr = p_rd;
    exp_data = m_load(rdata, p_addr, p_size, p_uns);
  endtask

  initial begin
    rst = 1'b1;
    cycle();
    chk_en = 1'b1;
    cycle();
    check("reset_data", rd_data_o, 32'h0);
    rst = 1'b0; exp_ready = 1'b1;
    idle(1);

    // ALU retire
    issue(WB_SEL_ALU, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 2'd0, 1'b0);
    check("alu_lit_we", 32'(wr_en), 32'd1);
    check("alu_lit_data", rd_data_o, 32'h1234_5678);
    idle(1);
    check("alu_pulse_end", 32'(wr_en), 32'd0);

    // Back-to-back PC+4 wrap then IMM
    issue(WB_SEL_PC4, 5'd7, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'h0, 2'd0, 1'b0);
    check("pc4_lit", rd_data_o, 32'h0000_0000);
    issue(WB_SEL_IMM, 5'd8, 1'b1, 32'h0, 32'h0, 32'hABCD_E000, 2'd0, 1'b0);
    check("imm_lit", rd_data_o, 32'hABCD_E000);
    idle(1);

    // x0 destination updates address/data but never writes
    issue(WB_SEL_ALU, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 2'd0, 1'b0);
    check("x0_lit_we", 32'(wr_en), 32'd0);
    idle(1);

    // Flush in IDLE drops the transfer; stray rvalid in IDLE is ignored
    wb_valid = 1'b1; flush = 1'b1; wb_sel = WB_SEL_ALU; rd_addr = 5'd9; rd_we = 1'b1;
    alu_result = 32'h7777_7777;
    cycle();
    wb_valid = 1'b0; flush = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
    cycle();
    dmem_rvalid = 1'b0;
    idle(1);

    // LB, offset 2, response on third wait cycle
    issue(WB_SEL_LOAD, 5'd10, 1'b1, 32'h1000_0002, 32'h0, 32'h0, LOAD_BYTE, 1'b0);
    wait_cycle();
    wait_cycle();
    respond(32'h0080_0000);
    check("lb_lit", rd_data_o, 32'hFFFF_FF80);
    idle(1);

    // LHU, upper half
    issue(WB_SEL_LOAD, 5'd11, 1'b1, 32'h2000_0002, 32'h0, 32'h0, LOAD_HALF, 1'b1);
    wait_cycle();
    respond(32'h8001_0000);
    check("lhu_lit", rd_data_o, 32'h0000_8001);
    // LH signed at offset 3 (low offset bit ignored)
    issue(WB_SEL_LOAD, 5'd12, 1'b1, 32'h2000_0003, 32'h0, 32'h0, LOAD_HALF, 1'b0);
    respond(32'h8001_0000);
    check("lh_lit", rd_data_o, 32'hFFFF_8001);
    // LBU offset 1
    issue(WB_SEL_LOAD, 5'd13, 1'b1, 32'h2000_0001, 32'h0, 32'h0, LOAD_BYTE, 1'b1);
    respond(32'h0000_9A00);
    // Size 11 behaves as a word
    issue(WB_SEL_LOAD, 5'd14, 1'b1, 32'h2000_0001, 32'h0, 32'h0, 2'b11, 1'b0);
    respond(32'hCAFE_F00D);
    check("lw11_lit", rd_data_o, 32'hCAFE_F00D);
    idle(1);

    // Flush in WAIT_LOAD beats a simultaneous response
    issue(WB_SEL_LOAD, 5'd15, 1'b1, 32'h0, 32'h0, 32'h0, LOAD_WORD, 1'b0);
    wait_cycle();
    flush = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
    cycle();
    flush = 1'b0; dmem_rvalid = 1'b0;
    exp_busy = 1'b0; exp_ready = 1'b1;
    check("flush_lit_ready", 32'(wb_ready), 32'd1);
    check("flush_lit_err", 32'(err), 32'd0);
    idle(1);

    // Timeout: no response for TO cycles
    issue(WB_SEL_LOAD, 5'd16, 1'b1, 32'h0, 32'h0, 32'h0, LOAD_WORD, 1'b0);
    for (int k = 0; k < TO; k++) wait_cycle();
    check("timeout_lit_err", 32'(err), 32'd1);
    idle(2);

    // Unit keeps working after the timeout; error stays set
    issue(WB_SEL_ALU, 5'd3, 1'b1, 32'h0000_0055, 32'h0, 32'h0, 2'd0, 1'b0);
    check("post_to_lit", rd_data_o, 32'h0000_0055);
    idle(1);

    // Reset in the middle of a load, then a late response
    issue(WB_SEL_LOAD, 5'd17, 1'b1, 32'h0, 32'h0, 32'h0, LOAD_WORD, 1'b0);
    wait_cycle();
    rst = 1'b1;
    cycle();
    exp_busy = 1'b0; exp_ready = 1'b0; exp_err = 1'b0; exp_addr = '0; exp_data = '0;
    rst = 1'b0; exp_ready = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h2222_2222;
    cycle();
    dmem_rvalid = 1'b0;
    check("late_rvalid_lit", 32'(wr_en), 32'd0);
    idle(2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/rv32_writeback_unit.md
Name: rv32_writeback_unit

Overview:
- Writer side of the RV32I register file: retires one instruction per transaction and drives the register file's write port (write enable, destination address, write data).
- Selects the result source: ALU, load, PC+4 or immediate.
- Waits for data-memory load responses, then aligns and sign/zero-extends load data.
- Sits between the MEM stage (valid/ready handshake) and the register file, with a bounded wait and a sticky error on missing load responses.

Parameters:
- LOAD_TIMEOUT, 16, maximum cycles spent in WAIT_LOAD before the load is abandoned (1..255).
- XLEN, 32, datapath width (fixed at 32 for RV32I).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset, synchronous, active-high.
- wb_valid_in  input  1  MEM stage presents a retiring instruction.
- wb_ready_out  output  1  unit can accept; combinational, = (state==IDLE) && !rst_in.
- rd_addr_in  input  5  destination register.
- rd_we_in  input  1  instruction writes rd.
- wb_sel_in  input  2  result source: 00 ALU, 01 LOAD, 10 PC+4, 11 IMM.
- alu_result_in  input  32  ALU result; also the load address for alignment.
- pc_in  input  32  instruction PC.
- imm_in  input  32  U-type immediate (LUI).
- load_size_in  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
- load_unsigned_in  input  1  zero-extend (LBU/LHU) when 1.
- dmem_rvalid_in  input  1  load response valid.
- dmem_rdata_in  input  32  load response word (word-aligned).
- flush_in  input  1  cancel pending/accepting instruction.
- wr_en_out  output  1  register-file write enable, one-cycle pulse.
- rd_addr_out  output  5  register-file write address.
- rd_data_out  output  32  register-file write data.
- busy_out  output  1  high in WAIT_LOAD.
- err_out  output  1  sticky load-timeout flag.

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE, timeout counter 0.
  - wr_en_out=0, rd_addr_out=0, rd_data_out=0, busy_out=0, err_out=0.
  - wb_ready_out=0 while rst_in is high.
- States are IDLE and WAIT_LOAD.
- Accept occurs when wb_valid_in && wb_ready_out && !flush_in. If flush_in is high in IDLE, the transfer is dropped; no write and no state change.
- IDLE, accept, wb_sel_in != 01:
  - Result is ALU = alu_result_in, PC+4 = pc_in+4 (mod 2^32), or IMM = imm_in.
  - Next cycle: rd_data_out = result, rd_addr_out = rd_addr_in, wr_en_out = rd_we_in && (rd_addr_in!=0).
  - Latency 1; back-to-back accepts every cycle.
- IDLE, accept, wb_sel_in == 01:
  - Capture rd_addr, rd_we, load_size, load_unsigned and alu_result_in[1:0].
  - Go to WAIT_LOAD and clear the counter; wr_en_out=0 next cycle.
- WAIT_LOAD: wb_ready_out=0, busy_out=1, wr_en_out=0; the counter increments each cycle without rvalid.
  - dmem_rvalid_in=1 (checked before timeout): format the data. Next cycle: wr_en_out pulses per the captured rd_we && rd!=0, and state returns to IDLE.
  - Counter reaches LOAD_TIMEOUT-1 with no rvalid: set err_out, no write, return to IDLE.
  - flush_in=1: abandon with no write and no error, return to IDLE. Flush has priority over rvalid in the same cycle.
- Load formatting, with off = captured addr[1:0]:
  - byte = rdata[8*off +: 8].
  - half = rdata[16*off[1] +: 16]; off[0] is ignored, because misalignment is trapped upstream.
  - word = rdata.
  - Sign-extend unless load_unsigned.
- rd_addr 0 never produces wr_en_out=1. rd_addr_out/rd_data_out still update.
- wr_en_out is a registered pulse; it is 0 in every cycle without a completing instruction.
- dmem_rvalid_in outside WAIT_LOAD is ignored.
- err_out clears only on reset.

Decomposition:
- Shared package rv32_pkg holds:
  - WB_SEL_ALU/LOAD/PC4/IMM encodings.
  - LOAD_BYTE/HALF/WORD size encodings.
  - wb_state_t {IDLE, WAIT_LOAD}.
- One combinational sub-module, load_align_ext (rdata, offset, size, unsigned -> 32-bit data), reusable by the MEM stage.

Test Plan:
- ALU retire: accept rd=5, sel=00, alu=0x1234_5678, we=1 -> next cycle wr_en_out=1, rd_addr_out=5, rd_data_out=0x1234_5678; following cycle wr_en_out=0.
- Back-to-back: PC+4 with pc=0xFFFF_FFFC, then IMM=0xABCD_E000 on consecutive cycles -> writes 0x0000_0000 then 0xABCD_E000 on consecutive cycles.
- Signed load: LB, addr[1:0]=2, rdata=0x0080_0000 after 3 wait cycles -> busy_out high 3 cycles, then wr_en_out=1 with rd_data_out=0xFFFF_FF80. Same with LHU, addr[1]=1, rdata=0x8001_0000 -> 0x0000_8001.
- Timeout: LOAD_TIMEOUT=4, load accepted, no rvalid -> return to IDLE after 4 cycles, err_out=1 sticky, no write; next ALU instruction still accepted.
- x0 and flush: ALU instruction to rd=0 -> wr_en_out stays 0. Flush in WAIT_LOAD with simultaneous rvalid -> no write, err_out=0, wb_ready_out=1 next cycle.
- Reset mid-load: rst_in high during WAIT_LOAD -> next cycle all outputs 0, state IDLE; a late rvalid is ignored.
